poly_add_ctrl: RTL
==================

// Module: poly_add_ctrl
// PURPOSE
//  Sequencer for the pipelined mod-3329 coefficient adder (add/add-halve) in the NTT unit.
//  On start, streams one N-coefficient job: drives a shared read address to both polynomial banks.
//  Bank data feeds the adder directly; the block holds adder mode stable and issues write-backs.
//  Sits between the NTT top-level FSM (start/done) and the coefficient RAMs + adder.
// PARAMETERS
//  N          256  coefficients per polynomial (power of 2)
//  AW         8    address width, log2(N)
//  RD_LAT     1    RAM read latency, cycles (rd_en/addr -> data at adder input)
//  ADD_LAT    2    adder latency, cycles (operands -> res valid)
//  MODE_SETUP 2    cycles add_mode must be stable before the first operand
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   reset, asynchronous, active-high
//  start     in   1   job request; sampled in IDLE only
//  mode_in   in   2   1 = add then halve (x*2^-1 mod q); any other value = plain add
//  busy      out  1   high from cycle after accepted start through DONE
//  done      out  1   one-cycle pulse, job complete (last write issued previous cycle)
//  rd_en     out  1   read strobe to both banks
//  rd_addr   out  AW  coefficient index being read
//  add_mode  out  2   mode to adder, constant for whole job
//  wr_en     out  1   write strobe for adder result
//  wr_addr   out  AW  destination index, = rd_addr delayed LAT = RD_LAT+ADD_LAT
//  stall     in   1   (only with POLY_ADD_STALL_EN) freeze issue
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, add_mode = 0; delay line clear.
//  FSM: IDLE -> SETUP (start=1) -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches mode_in to add_mode, next SETUP. start in any other state is ignored.
//  SETUP: MODE_SETUP cycles, rd_en=0, add_mode driven; next ISSUE with rd_addr=0.
//  ISSUE: rd_en=1 each cycle, rd_addr increments 0..N-1; after N-1 issued -> DRAIN.
//   rd_addr not wrapped: counter is AW+1 bits internally, terminal count N-1.
//  DRAIN: rd_en=0 for exactly LAT cycles so all in-flight results write back; -> DONE.
//  DONE: done=1, busy=1 for one cycle; -> IDLE (busy=0 next cycle).
//  Write path: LAT-deep shift register of {valid, addr}; wr_en/wr_addr are its output.
//   Bubbles in rd_en propagate as wr_en=0 bubbles; write order = read order.
//  add_mode only changes in IDLE on accepted start; held through DONE (adder mode pipeline).
//  mode_in 2 or 3: passed through unchanged; adder treats as plain add.
//  Reset mid-job: immediate abort, no done pulse, delay line flushed (no late wr_en).
//  Back-to-back: start high in the cycle after DONE is accepted (IDLE sees it).
//  Timing (defaults, C0 = edge sampling start): busy 1..262, rd_en 3..258,
//   wr_en 6..261, done at 262.
// CONFIGURATION
//  POLY_ADD_STALL_EN defined: stall port exists. In ISSUE, stall=1 -> rd_en=0, rd_addr holds,
//   no state change; delay line keeps shifting (bubbles). stall ignored in other states.
//   DRAIN starts only after the final address is issued with stall=0.
//  Not defined: no stall port; ISSUE always lasts exactly N cycles.
// TESTING
//  1 rst; start=1 mode=0 one cycle -> rd_en C0+3..C0+258, rd_addr 0..255;
//    wr_en C0+6..C0+261, wr_addr 0..255; done C0+262 only; adder-model results match RAM.
//  2 mode=1, A[i]=3328, B[i]=1 -> every write = 0; A[i]=1, B[i]=2 -> every write = 1666.
//  3 start pulsed while busy (C0+100) -> ignored; single done, add_mode unchanged.
//  4 rst asserted at C0+150 -> all outputs 0 same cycle; no wr_en/done afterwards; restart works.
//  5 start held high across DONE -> second job: busy low 1 cycle, second rd_en begins 3 cycles later.
//  6 (STALL_EN) stall=1 C0+10..C0+14 -> rd_addr holds 7; 5 wr_en bubbles; done at C0+267.

Source files
------------

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: sequencer for the pipelined mod-3329 coefficient adder; streams one N-coefficient job.
// Optional feature macro: POLY_ADD_STALL_EN adds a stall input that freezes address issue.
`default_nettype none

module poly_add_ctrl #(
  parameter int N          = 256,
  parameter int AW         = 8,
  parameter int RD_LAT     = 1,
  parameter int ADD_LAT    = 2,
  parameter int MODE_SETUP = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef POLY_ADD_STALL_EN
  input  logic          stall,
`endif
  input  logic          start,
  input  logic [1:0]    mode_in,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [1:0]    add_mode,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
);

  localparam int          LAT  = RD_LAT + ADD_LAT;
  localparam int          TMAX = (MODE_SETUP > LAT) ? MODE_SETUP : LAT;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam logic [AW:0] LAST = (AW+1)'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW:0]   cnt;
  logic [TW-1:0] tcnt;
  logic          issue_hold;

`ifdef POLY_ADD_STALL_EN
  assign issue_hold = stall;
`else
  assign issue_hold = 1'b0;
`endif

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = cnt[AW-1:0];
    case (state)
      S_IDLE: begin
        if (start) state_n = S_SETUP;
      end
      S_SETUP: begin
        busy = 1'b1;
        if (tcnt == TW'(MODE_SETUP - 1)) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        busy  = 1'b1;
        rd_en = !issue_hold;
        if (!issue_hold && cnt == LAST) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tcnt == TW'(LAT - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // tcnt times SETUP and DRAIN; cnt is one bit wider than the address so the last issue never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      add_mode <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        tcnt <= '0;
      else if (state == S_SETUP || state == S_DRAIN)
        tcnt <= tcnt + TW'(1);
      if (state == S_IDLE) begin
        cnt <= '0;
        if (start) add_mode <= mode_in;
      end else if (rd_en) begin
        cnt <= cnt + (AW+1)'(1);
      end
    end
  end

  logic [LAT-1:0] dl_vld;
  logic [AW-1:0]  dl_addr [LAT];

  // Write-back delay line: read bubbles become write bubbles, order preserved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld <= '0;
      for (int i = 0; i < LAT; i++) dl_addr[i] <= '0;
    end else begin
      dl_vld[0]  <= rd_en;
      dl_addr[0] <= rd_addr;
      for (int i = 1; i < LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

  assign wr_en   = dl_vld[LAT-1];
  assign wr_addr = dl_addr[LAT-1];

endmodule

`default_nettype wire
